// File: rtl/clip_controller.sv
// clip_controller
// Two-clip sample recorder / player sequencer. It turns button edges and the
// audio sample strobe into write/read strobes for an external sample memory.
// The memory is split into two clips of 2^ADDR_W samples each, and the block
// remembers how many samples each clip holds.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   record       synchronized record button level
//   play         synchronized play button level
//   clip_sel_wr  clip to record into (0 / 1)
//   clip_sel_r   clip to play back (0 / 1)
//   sample_tick  one-cycle strobe at the audio sample rate
//   mem_addr     {clip, sample index}; holds its value between strobes
//   mem_we       one-cycle write strobe (registered)
//   mem_re       one-cycle read strobe (registered)
//   recording    high while in RECORD (registered)
//   playing      high while in PLAY (registered)
//   done         one-cycle pulse when a clip ends by itself; it coincides
//                with the final mem_we / mem_re
//   dbg_state    current FSM state, for observation only
//
// Handshake: no valid/ready is used. Each sample_tick accepted in RECORD or
// PLAY produces exactly one strobe on the following cycle. Ticks seen in
// IDLE, or in the same cycle as a stopping button edge, are dropped.
module clip_controller #(
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              record,
  input  logic              play,
  input  logic              clip_sel_wr,
  input  logic              clip_sel_r,
  input  logic              sample_tick,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic              recording,
  output logic              playing,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECORD = 2'd1;
  localparam logic [1:0] S_PLAY   = 2'd2;

  // A full clip holds 2^ADDR_W samples. The counter is one bit wider than the
  // sample index so that this full count fits in a length register.
  localparam logic [ADDR_W:0] CLIP_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_IDX  = {1'b0, {ADDR_W{1'b1}}};

  logic [1:0]      state;
  logic            clip;
  logic [ADDR_W:0] counter;
  logic [ADDR_W:0] len [2];
  logic            record_q;
  logic            play_q;
  logic            rec_edge;
  logic            play_edge;

  // The edge registers reset to 0. A button that is held through reset
  // release therefore registers as an edge on the first clock.
  assign rec_edge  = record & ~record_q;
  assign play_edge = play & ~play_q;
  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      clip      <= 1'b0;
      counter   <= '0;
      len[0]    <= '0;
      len[1]    <= '0;
      record_q  <= 1'b0;
      play_q    <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      recording <= 1'b0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else begin
      record_q <= record;
      play_q   <= play;
      // Strobes default low, so each one lasts a single cycle.
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      done     <= 1'b0;

      case (state)
        S_IDLE: begin
          // When both buttons have an edge in the same cycle, record wins.
          if (rec_edge) begin
            state     <= S_RECORD;
            clip      <= clip_sel_wr;
            counter   <= '0;
            recording <= 1'b1;
          end else if (play_edge && (len[clip_sel_r] != '0)) begin
            state   <= S_PLAY;
            clip    <= clip_sel_r;
            counter <= '0;
            playing <= 1'b1;
          end
        end

        S_RECORD: begin
          // A stop edge takes priority over a coincident tick. The sample
          // count is committed when recording stops, so the other clip's
          // length is never touched.
          if (rec_edge) begin
            len[clip] <= counter;
            state     <= S_IDLE;
            recording <= 1'b0;
          end else if (sample_tick) begin
            mem_we   <= 1'b1;
            mem_addr <= {clip, counter[ADDR_W-1:0]};
            counter  <= counter + 1'b1;
            // Writing the last slot of the clip ends recording. This keeps
            // the counter from wrapping into the start of the clip.
            if (counter == LAST_IDX) begin
              len[clip] <= CLIP_FULL;
              done      <= 1'b1;
              state     <= S_IDLE;
              recording <= 1'b0;
            end
          end
        end

        S_PLAY: begin
          if (play_edge) begin
            state   <= S_IDLE;
            playing <= 1'b0;
          end else if (sample_tick) begin
            mem_re   <= 1'b1;
            mem_addr <= {clip, counter[ADDR_W-1:0]};
            counter  <= counter + 1'b1;
            // PLAY is only entered with a nonzero length, so len-1 is valid.
            if (counter == (len[clip] - 1'b1)) begin
              done    <= 1'b1;
              state   <= S_IDLE;
              playing <= 1'b0;
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          recording <= 1'b0;
          playing   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clip_controller.sv
// Testbench for clip_controller, built with ADDR_W = 3 (clips of 8 samples).
// Stimulus tasks push each expected strobe {we, re, done, addr} into exp_q.
// A monitor process running on the falling clock edge pops one entry for
// every strobe the DUT presents and compares it.
module tb_clip_controller;
  localparam int ADDR_W = 3;
  localparam int EW     = ADDR_W + 4;

  logic              clock;
  logic              reset;
  logic              record;
  logic              play;
  logic              clip_sel_wr;
  logic              clip_sel_r;
  logic              sample_tick;
  logic [ADDR_W:0]   mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic              recording;
  logic              playing;
  logic              done;
  logic [1:0]        dbg_state;

  logic [EW-1:0]     exp_q[$];
  int                checks;
  int                errors;

  clip_controller #(.ADDR_W(ADDR_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .record      (record),
    .play        (play),
    .clip_sel_wr (clip_sel_wr),
    .clip_sel_r  (clip_sel_r),
    .sample_tick (sample_tick),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .recording   (recording),
    .playing     (playing),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic we, input logic re, input logic dn,
                               input logic [ADDR_W:0] addr);
    exp_q.push_back({we, re, dn, addr});
  endfunction

  // driver tasks: inputs change on the falling edge
  task automatic press_record();
    @(negedge clock); record = 1'b1;
    @(negedge clock); record = 1'b0;
  endtask

  task automatic press_play();
    @(negedge clock); play = 1'b1;
    @(negedge clock); play = 1'b0;
  endtask

  task automatic press_both();
    @(negedge clock); record = 1'b1; play = 1'b1;
    @(negedge clock); record = 1'b0; play = 1'b0;
  endtask

  task automatic tick();
    @(negedge clock); sample_tick = 1'b1;
    @(negedge clock); sample_tick = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (mem_we && mem_re) chk("we_re_exclusive", {mem_we, mem_re}, 2'b00);
        if (mem_we || mem_re) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_strobe", {mem_we, mem_re, done, mem_addr}, '0);
          end else begin
            e = exp_q.pop_front();
            chk("strobe", {mem_we, mem_re, done, mem_addr}, e);
          end
        end else if (done) begin
          chk("done_without_strobe", done, 1'b0);
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; record = 1'b0; play = 1'b0;
    clip_sel_wr = 1'b0; clip_sel_r = 1'b0; sample_tick = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_addr", mem_addr, 0);
    chk("reset_flags", {mem_we, mem_re, recording, playing, done}, 0);
    chk("reset_state", dbg_state, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Record clip 0 for 5 samples. A play edge during recording is ignored.
    clip_sel_wr = 1'b0;
    press_record();
    chk("rec0_recording", recording, 1);
    for (int i = 0; i < 5; i++) begin
      push(1'b1, 1'b0, 1'b0, 4'(i));
      tick();
      if (i == 2) begin
        press_play();
        chk("rec0_play_ignored", {recording, playing}, 2'b10);
      end
    end
    press_record();
    chk("rec0_stopped", {recording, playing, dbg_state}, 0);

    // Play clip 0: 5 reads, with done on the last one.
    clip_sel_r = 1'b0;
    press_play();
    chk("play0_playing", {recording, playing}, 2'b01);
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 1'b1, (i == 4), 4'(i));
      tick();
    end
    @(negedge clock);
    chk("play0_ended", {playing, dbg_state}, 0);
    chk("addr_hold", mem_addr, 4);

    // Clip 1 is empty, so a play request does nothing and a tick is dropped.
    clip_sel_r = 1'b1;
    press_play();
    chk("play1_empty", {playing, dbg_state}, 0);
    tick();

    // Record clip 1 for 10 ticks: 8 writes at 8..15, done on the 8th.
    clip_sel_wr = 1'b1;
    press_record();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) push(1'b1, 1'b0, (i == 7), 4'(8 + i));
      tick();
      if (i == 7) chk("rec1_full_idle", {recording, dbg_state}, 0);
    end

    // Play clip 1 to show len[1] = 8, then clip 0 to show len[0] is still 5.
    press_play();
    for (int i = 0; i < 8; i++) begin
      push(1'b0, 1'b1, (i == 7), 4'(8 + i));
      tick();
    end
    clip_sel_r = 1'b0;
    press_play();
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 1'b1, (i == 4), 4'(i));
      tick();
    end
    chk("play0_again_ended", playing, 0);

    // Record and play edges together: record wins. Stopping at once sets len 0.
    clip_sel_wr = 1'b0;
    press_both();
    chk("both_record_wins", {recording, playing, dbg_state}, {2'b10, 2'd1});
    push(1'b1, 1'b0, 1'b0, 4'd0);
    @(negedge clock); record = 1'b1; sample_tick = 1'b0;
    @(negedge clock); record = 1'b0;
    exp_q.delete();
    chk("zero_len_stop", recording, 0);
    press_play();
    chk("zero_len_no_play", playing, 0);

    // Record 3 samples, then abort playback with a play edge and a tick in the
    // same cycle: no read is expected.
    press_record();
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 1'b0, 1'b0, 4'(i));
      tick();
    end
    @(negedge clock); record = 1'b1; sample_tick = 1'b1;
    @(negedge clock); record = 1'b0; sample_tick = 1'b0;
    chk("stop_tick_dropped", {recording, mem_we}, 0);
    press_play();
    push(1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    @(negedge clock); play = 1'b1; sample_tick = 1'b1;
    @(negedge clock); play = 1'b0; sample_tick = 1'b0;
    chk("abort_play", {playing, mem_re, done}, 0);

    // Reset during playback, after 2 reads.
    press_play();
    push(1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    push(1'b0, 1'b1, 1'b0, 4'd1);
    tick();
    chk("pre_reset_playing", {playing, mem_addr}, {1'b1, 4'd1});
    #2 reset = 1'b0;
    #1;
    chk("async_reset_outputs", {mem_addr, mem_we, mem_re, recording, playing, done}, 0);
    chk("async_reset_state", dbg_state, 0);
    @(negedge clock); reset = 1'b1;
    clip_sel_r = 1'b0;
    press_play();
    chk("len0_cleared", playing, 0);
    clip_sel_r = 1'b1;
    press_play();
    chk("len1_cleared", playing, 0);

    // A button held through reset release counts as an edge.
    @(negedge clock); reset = 1'b0; record = 1'b1;
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    chk("held_button_edge", recording, 1);
    record = 1'b0;
    press_record();
    chk("held_button_stop", recording, 0);

    repeat (3) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
